// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// default handler vector layout and the fixed-priority encoder.
package intc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAKE    = 2'd1,
      SERVICE = 2'd2
   } intc_state_t;

   localparam int unsigned DEF_VEC_BASE   = 32'h3C0;
   localparam int unsigned DEF_VEC_STRIDE = 16;

   // Lowest set index wins; returns 0 when nothing is requested.
   function automatic logic [2:0] prio_encode(input logic [7:0] req);
      logic [2:0] id;
      id = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) id = 3'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/intc_if.sv
// Interrupt handshake bundle between the interrupt controller and the
// control unit.  The master modport is the controller (requesting side);
// the slave modport is the control unit / environment.
interface intc_if #(
   parameter int N_IRQ = 4,
   parameter int VEC_W = 10,
   parameter int TMR_W = 16
);
   logic [N_IRQ-1:0] irq_in;
   logic [N_IRQ-1:0] irq_mask;
   logic             fetch_ok;
   logic             s_finish_interr;
   logic [TMR_W-1:0] tmr_period;
   logic             s_interruption;
   logic [VEC_W-1:0] int_vector;
   logic [2:0]       int_id;
   logic             in_service;
   logic [N_IRQ-1:0] pending;

   modport master (
      input  irq_in, irq_mask, fetch_ok, s_finish_interr, tmr_period,
      output s_interruption, int_vector, int_id, in_service, pending
   );

   modport slave (
      output irq_in, irq_mask, fetch_ok, s_finish_interr, tmr_period,
      input  s_interruption, int_vector, int_id, in_service, pending
   );
endinterface

// File: rtl/intc_sync_edge.sv
// Single-line two-flop synchroniser followed by a rising-edge detector.
// edge_pulse is high for one cycle, two edges after the input is sampled high.
module intc_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic edge_pulse
);
   logic sync1;
   logic sync2;
   logic prev;

   // Synchroniser chain plus the delayed copy used for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= async_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign edge_pulse = sync2 & ~prev;
endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: latches synchronised IRQ edges as pending, takes the
// highest-priority unmasked line at an instruction boundary, pulses
// s_interruption once and holds the handler vector until FNSH completes.
// Optional feature: define INTC_TIMER_EN for an internal periodic timer that
// raises line 0.
module interrupt_ctrl
   import intc_pkg::*;
#(
   parameter int          N_IRQ      = 4,
   parameter int          VEC_W      = 10,
   parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
   parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE,
   parameter int          TMR_W      = 16
) (
   input logic   clk,
   input logic   reset,
   intc_if.master bus
);
   intc_state_t      state_q, state_d;
   logic [2:0]       id_q, id_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [N_IRQ-1:0] pending_q, pending_d;
   logic [N_IRQ-1:0] edge_vec;
   logic [N_IRQ-1:0] set_vec;
   logic [N_IRQ-1:0] clr_vec;
   logic [N_IRQ-1:0] req;
   logic [7:0]       clr_ext;
   logic [2:0]       sel_id;
   logic [VEC_W-1:0] vec_calc;
   logic             tmr_fire;

   for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
      intc_sync_edge u_sync (
         .clk        (clk),
         .reset      (reset),
         .async_in   (bus.irq_in[g]),
         .edge_pulse (edge_vec[g])
      );
   end

`ifdef INTC_TIMER_EN
   logic [TMR_W-1:0] tmr_cnt;
   logic             tmr_armed;

   assign tmr_fire = tmr_armed && (tmr_cnt == '0) && (bus.tmr_period != '0);

   // Down-counter: loads after reset or on expiry, idles while period is 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmr_cnt   <= '0;
         tmr_armed <= 1'b0;
      end else if (bus.tmr_period == '0) begin
         tmr_cnt   <= '0;
         tmr_armed <= 1'b0;
      end else if (!tmr_armed || tmr_cnt == '0) begin
         tmr_cnt   <= bus.tmr_period;
         tmr_armed <= 1'b1;
      end else begin
         tmr_cnt   <= tmr_cnt - 1'b1;
      end
   end
`else
   logic unused_tmr;
   assign unused_tmr = ^bus.tmr_period;
   assign tmr_fire   = 1'b0;
`endif

   assign req      = pending_q & bus.irq_mask;
   assign sel_id   = prio_encode(8'(req));
   assign vec_calc = VEC_W'(VEC_BASE + {29'd0, sel_id} * VEC_STRIDE);
   assign clr_ext  = 8'd1 << id_q;

   // Pending update: a new set wins over the take-cycle clear of the same bit.
   always_comb begin
      set_vec    = edge_vec;
      set_vec[0] = edge_vec[0] | tmr_fire;
      clr_vec    = '0;
      if (state_q == TAKE) clr_vec = clr_ext[N_IRQ-1:0];
      pending_d  = (pending_q & ~clr_vec) | set_vec;
   end

   // State, selected id, vector and pending register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         id_q      <= '0;
         vec_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         vec_q     <= vec_d;
         pending_q <= pending_d;
      end
   end

   // Next-state and handshake outputs; no nesting while a handler runs.
   always_comb begin
      state_d            = state_q;
      id_d               = id_q;
      vec_d              = vec_q;
      bus.s_interruption = 1'b0;
      bus.in_service     = 1'b0;
      case (state_q)
         IDLE: begin
            if ((|req) && bus.fetch_ok) begin
               state_d = TAKE;
               id_d    = sel_id;
               vec_d   = vec_calc;
            end
         end
         TAKE: begin
            bus.s_interruption = 1'b1;
            state_d            = SERVICE;
         end
         SERVICE: begin
            bus.in_service = 1'b1;
            if (bus.s_finish_interr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.int_id     = id_q;
   assign bus.int_vector = vec_q;
   assign bus.pending    = pending_q;
endmodule
